// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and polarity helpers for 7-segment display blocks
//
// Purpose: glyph table (logical form, 1 = lit, bits g..a), digit-count limit
// and helpers that map a logical segment pattern onto pin polarity.
// Ports: none (package).
package seg7_pkg;

   localparam int MAX_DIGITS = 8;

   // Hex glyphs 0-F, logical form, bit0 = a ... bit6 = g.
   localparam logic [6:0] GLYPHS [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   // Pin pattern for a logical segment pattern.
   function automatic logic [6:0] SEG_ON(input logic [6:0] lit, input logic active_low);
      return active_low ? ~lit : lit;
   endfunction

   // Pin pattern with every segment dark.
   function automatic logic [6:0] SEG_OFF(input logic active_low);
      return active_low ? 7'h7F : 7'h00;
   endfunction

endpackage

// File: rtl/seg7_glyph_rom.sv
// rtl/seg7_glyph_rom.sv - hex nibble to logical 7-segment glyph
//
// Purpose: purely combinational lookup of the shared glyph table.
// Ports:
//   nibble  in  4  hex digit 0-F
//   glyph   out 7  logical segments (1 = lit), bit0 = a ... bit6 = g
module seg7_glyph_rom
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] glyph
);

   assign glyph = GLYPHS[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed N-digit hex 7-segment scan driver
//
// Purpose: double-buffered (pending/active) digit registers, prescaled digit
// scan, leading-zero blanking, anti-ghosting gap and registered pin outputs.
// Ports:
//   clk         in  1             system clock, rising edge
//   rst_n       in  1             asynchronous active-low reset
//   enable      in  1             1 = scanning, 0 = display dark
//   load        in  1             strobe capturing value/dp_in/blank_lz
//   value       in  4*NUM_DIGITS  nibble i drives digit i (digit 0 rightmost)
//   dp_in       in  NUM_DIGITS    decimal point per digit
//   blank_lz    in  1             leading-zero blanking request
//   seg         out 7             segment pins, bit0 = a ... bit6 = g
//   dp          out 1             decimal point pin
//   dig_sel     out NUM_DIGITS    one-hot digit enable pins
//   frame_done  out 1             pulse after the last digit slot of a frame
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int   NUM_DIGITS     = 4,
   parameter int   SCAN_DIV       = 50000,
   parameter logic SEG_ACTIVE_LOW = 1'b1,
   parameter logic DIG_ACTIVE_LOW = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      enable,
   input  logic                      load,
   input  logic [4*NUM_DIGITS-1:0]   value,
   input  logic [NUM_DIGITS-1:0]     dp_in,
   input  logic                      blank_lz,
   output logic [6:0]                seg,
   output logic                      dp,
   output logic [NUM_DIGITS-1:0]     dig_sel,
   output logic                      frame_done
);

   localparam int CNT_W = $clog2(SCAN_DIV);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{DIG_ACTIVE_LOW}};

   logic [CNT_W-1:0]        cnt;
   logic [IDX_W-1:0]        idx;

   logic [4*NUM_DIGITS-1:0] pend_value, act_value;
   logic [NUM_DIGITS-1:0]   pend_dp, act_dp;
   logic                    pend_blank, act_blank;
   // Valid flags keep the display dark after reset until real data is committed.
   logic                    pend_valid, act_valid;

   logic                    wrap;
   logic [NUM_DIGITS-1:0]   lz_mask;
   logic [3:0]              cur_nib;
   logic                    cur_dp;
   logic                    cur_blank;
   logic [NUM_DIGITS-1:0]   cur_onehot;
   logic [6:0]              cur_glyph;
   logic                    lit;

   assign wrap = enable && (cnt == CNT_LAST) && (idx == IDX_LAST);

   // Prescaler and digit index; both parked at 0 while disabled so that
   // re-enabling always starts at digit 0, slot cycle 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         idx <= '0;
      end else if (!enable) begin
         cnt <= '0;
         idx <= '0;
      end else if (cnt == CNT_LAST) begin
         cnt <= '0;
         idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_value <= '0;
         pend_dp    <= '0;
         pend_blank <= 1'b0;
         pend_valid <= 1'b0;
      end else if (load) begin
         pend_value <= value;
         pend_dp    <= dp_in;
         pend_blank <= blank_lz;
         pend_valid <= 1'b1;
      end
   end

   // Active copy only changes at a frame boundary (or at once when dark), so a
   // frame never mixes two loads. A load on the wrap cycle bypasses pending.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_value <= '0;
         act_dp    <= '0;
         act_blank <= 1'b0;
         act_valid <= 1'b0;
      end else if (load && (!enable || wrap)) begin
         act_value <= value;
         act_dp    <= dp_in;
         act_blank <= blank_lz;
         act_valid <= 1'b1;
      end else if (wrap) begin
         act_value <= pend_value;
         act_dp    <= pend_dp;
         act_blank <= pend_blank;
         act_valid <= pend_valid;
      end
   end

   // lz_mask[i]: blanking requested and every nibble from the top down to i is zero.
   always_comb begin
      logic run;
      lz_mask = '0;
      run     = act_blank;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         run        = run && (act_value[i*4 +: 4] == 4'h0);
         lz_mask[i] = run;
      end
   end

   always_comb begin
      cur_nib    = 4'h0;
      cur_dp     = 1'b0;
      cur_blank  = 1'b0;
      cur_onehot = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx == IDX_W'(i)) begin
            cur_nib       = act_value[i*4 +: 4];
            cur_dp        = act_dp[i];
            cur_blank     = lz_mask[i];
            cur_onehot[i] = 1'b1;
         end
      end
   end

   seg7_glyph_rom u_glyph_rom (
      .nibble (cur_nib),
      .glyph  (cur_glyph)
   );

   assign lit = enable && act_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg        <= SEG_OFF(SEG_ACTIVE_LOW);
         dp         <= SEG_ACTIVE_LOW;
         dig_sel    <= DIG_OFF;
         frame_done <= 1'b0;
      end else begin
         frame_done <= wrap;
         if (lit) begin
            seg     <= cur_blank ? SEG_OFF(SEG_ACTIVE_LOW) : SEG_ON(cur_glyph, SEG_ACTIVE_LOW);
            dp      <= cur_dp ^ SEG_ACTIVE_LOW;
            // Slot cycle 0 is a dark gap so the previous digit's segments never ghost.
            dig_sel <= (cnt == '0) ? DIG_OFF : (cur_onehot ^ DIG_OFF);
         end else begin
            seg     <= SEG_OFF(SEG_ACTIVE_LOW);
            dp      <= SEG_ACTIVE_LOW;
            dig_sel <= DIG_OFF;
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

   localparam int ND = 4;
   localparam int SD = 4;
   localparam int FR = ND * SD;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          enable;
   logic          load;
   logic [15:0]   value;
   logic [3:0]    dp_in;
   logic          blank_lz;

   logic [6:0]    seg_a, seg_b;
   logic          dp_a, dp_b;
   logic [3:0]    dig_a, dig_b;
   logic          fd_a, fd_b;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
      .dp_in(dp_in), .blank_lz(blank_lz), .seg(seg_a), .dp(dp_a), .dig_sel(dig_a),
      .frame_done(fd_a)
   );

   seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
      .dp_in(dp_in), .blank_lz(blank_lz), .seg(seg_b), .dp(dp_b), .dig_sel(dig_b),
      .frame_done(fd_b)
   );

   logic [6:0] glyph_tab [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   // Reference model: cycles since scanning started plus the two buffers.
   int          m_t;
   logic [15:0] m_pv, m_av;
   logic [3:0]  m_pd, m_ad;
   logic        m_pb, m_ab, m_pvalid, m_avalid;
   logic [6:0]  e_seg;
   logic        e_dp;
   logic [3:0]  e_dig;
   logic        e_fd;

   task automatic model_reset();
      m_t = 0;
      m_pv = '0; m_av = '0; m_pd = '0; m_ad = '0;
      m_pb = 0; m_ab = 0; m_pvalid = 0; m_avalid = 0;
      e_seg = '0; e_dp = 0; e_dig = '0; e_fd = 0;
   endtask

   // Expected outputs after the coming edge, from pre-edge inputs and state.
   task automatic model_edge();
      int d, s;
      logic wr, blank;
      e_seg = '0; e_dp = 0; e_dig = '0;
      if (enable && m_avalid) begin
         d = (m_t / SD) % ND;
         s = m_t % SD;
         blank = (d > 0) && m_ab && ((m_av >> (4 * d)) == 16'h0);
         e_seg = blank ? 7'h00 : glyph_tab[m_av[4*d +: 4]];
         e_dp  = m_ad[d];
         e_dig = (s == 0) ? 4'b0000 : 4'(1 << d);
      end
      wr = enable && ((m_t % FR) == FR - 1);
      e_fd = wr;
      if (load && (!enable || wr)) begin
         m_av = value; m_ad = dp_in; m_ab = blank_lz; m_avalid = 1;
      end else if (wr) begin
         m_av = m_pv; m_ad = m_pd; m_ab = m_pb; m_avalid = m_pvalid;
      end
      if (load) begin
         m_pv = value; m_pd = dp_in; m_pb = blank_lz; m_pvalid = 1;
      end
      m_t = enable ? m_t + 1 : 0;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic check_all();
      logic [6:0] n_seg;
      logic [3:0] n_dig;
      logic       n_dp;
      n_seg = ~e_seg;
      n_dig = ~e_dig;
      n_dp  = ~e_dp;
      chk("model_seg_b", seg_b, e_seg);
      chk("model_dp_b", dp_b, e_dp);
      chk("model_dig_b", dig_b, e_dig);
      chk("model_fd_b", fd_b, e_fd);
      chk("model_seg_a", seg_a, n_seg);
      chk("model_dp_a", dp_a, n_dp);
      chk("model_dig_a", dig_a, n_dig);
      chk("model_fd_a", fd_a, e_fd);
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   typedef struct packed {
      logic [15:0] value;
      logic [3:0]  dpv;
      logic        blz;
      logic [27:0] segs;   // logical glyphs {d3, d2, d1, d0}
   } vec_t;

   vec_t tbl [8];

   initial begin
      int first_fd, second_fd;

      tbl[0] = '{16'h1234, 4'b0000, 1'b0, {7'h06, 7'h5B, 7'h4F, 7'h66}};
      tbl[1] = '{16'hABCD, 4'b0000, 1'b0, {7'h77, 7'h7C, 7'h39, 7'h5E}};
      tbl[2] = '{16'hEF09, 4'b0000, 1'b0, {7'h79, 7'h71, 7'h3F, 7'h6F}};
      tbl[3] = '{16'h0070, 4'b1000, 1'b1, {7'h00, 7'h00, 7'h07, 7'h3F}};
      tbl[4] = '{16'h0000, 4'b0000, 1'b1, {7'h00, 7'h00, 7'h00, 7'h3F}};
      tbl[5] = '{16'h0070, 4'b0000, 1'b0, {7'h3F, 7'h3F, 7'h07, 7'h3F}};
      tbl[6] = '{16'h0800, 4'b0001, 1'b1, {7'h00, 7'h7F, 7'h3F, 7'h3F}};
      tbl[7] = '{16'h5678, 4'b0100, 1'b0, {7'h6D, 7'h7D, 7'h07, 7'h7F}};

      rst_n = 0; enable = 0; load = 0; value = '0; dp_in = '0; blank_lz = 0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("reset_seg_a", seg_a, 7'h7F);
      chk("reset_dp_a", dp_a, 1'b1);
      chk("reset_dig_a", dig_a, 4'hF);
      chk("reset_seg_b", seg_b, 7'h00);
      chk("reset_dig_b", dig_b, 4'h0);
      chk("reset_fd", fd_a, 1'b0);
      rst_n = 1;

      // Glyphs, blanking and dp per digit, loaded while dark then scanned one frame.
      for (int e = 0; e < 8; e++) begin
         value = tbl[e].value; dp_in = tbl[e].dpv; blank_lz = tbl[e].blz;
         load = 1; enable = 0;
         tick();
         load = 0; enable = 1;
         for (int k = 1; k <= FR; k++) begin
            tick();
            if (k >= 2 && ((k - 2) % SD) == 0) begin
               int d;
               d = (k - 2) / SD;
               chk("tbl_seg", seg_b, tbl[e].segs[7*d +: 7]);
               chk("tbl_dp", dp_b, tbl[e].dpv[d]);
               chk("tbl_dig", dig_b, 32'd1 << d);
            end
         end
         enable = 0;
         tick();
      end

      // frame_done cadence.
      first_fd = -1; second_fd = -1;
      value = 16'h1234; dp_in = '0; blank_lz = 0; load = 1; enable = 0;
      tick();
      load = 0; enable = 1;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (fd_b) begin
            if (first_fd < 0) first_fd = k;
            else if (second_fd < 0) second_fd = k;
         end
      end
      chk("fd_first", first_fd, 16);
      chk("fd_period", second_fd - first_fd, FR);

      // Tear-free: two loads mid-frame, old value holds until the wrap.
      for (int n = 0; n < 40 && (m_t % FR) != 5; n++) tick();
      value = 16'h1111; load = 1;
      tick();
      value = 16'h2222;
      tick();
      load = 0;
      for (int n = 0; n < 40 && (m_t % FR) != 14; n++) tick();
      chk("tear_old_d3_b", seg_b, 7'h06);
      chk("tear_old_d3_a", seg_a, 7'h79);
      for (int n = 0; n < 40 && (m_t % FR) != 2; n++) tick();
      chk("tear_new_d0", seg_b, 7'h5B);
      chk("tear_new_dig", dig_b, 4'b0001);

      // Load exactly on the wrap cycle.
      for (int n = 0; n < 40 && (m_t % FR) != FR - 1; n++) tick();
      value = 16'h3333; load = 1;
      tick();
      load = 0;
      tick();
      tick();
      chk("wrap_load_d0", seg_b, 7'h4F);
      chk("wrap_load_dig", dig_b, 4'b0001);

      // Disable mid-frame, load while dark, re-enable.
      repeat (3) tick();
      enable = 0;
      tick();
      chk("dis_seg_b", seg_b, 7'h00);
      chk("dis_dig_b", dig_b, 4'h0);
      chk("dis_seg_a", seg_a, 7'h7F);
      value = 16'h8888; load = 1;
      tick();
      load = 0; enable = 1;
      tick();
      tick();
      chk("reen_seg", seg_b, 7'h7F);
      chk("reen_dig", dig_b, 4'b0001);

      // Asynchronous reset mid-slot.
      tick();
      #2 rst_n = 0;
      #1;
      chk("areset_seg_a", seg_a, 7'h7F);
      chk("areset_dig_a", dig_a, 4'hF);
      chk("areset_dp_a", dp_a, 1'b1);
      chk("areset_dig_b", dig_b, 4'h0);
      model_reset();
      @(negedge clk);
      rst_n = 1;
      repeat (20) tick();
      chk("post_reset_dark", dig_b, 4'h0);
      value = 16'h00A0; blank_lz = 1; dp_in = 4'b0010; load = 1;
      tick();
      load = 0;
      repeat (40) tick();

      // Randomized traffic against the model.
      for (int n = 0; n < 800; n++) begin
         logic [15:0] v;
         v = 16'($urandom);
         value = v >> (4 * $urandom_range(0, 4));
         dp_in = 4'($urandom);
         blank_lz = 1'($urandom);
         load = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 49) == 0) enable = ~enable;
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
